task_ingress_arbiter: RTL and testbench
=======================================

TASK_INGRESS_ARBITER -- requirements
Module: task_ingress_arbiter

Interface
REQ-001 SHALL have parameter W, default 42, meaning task width including the VALID bit at W-1.
REQ-002 SHALL have parameter CH, default 4, meaning number of external task source channels (1..16).
REQ-003 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority (channel 0 highest).
REQ-004 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, CH bits: per-channel task offered.
REQ-008 SHALL have port in_task, input, CH*W bits: channel i occupies bits [i*W+W-1 : i*W].
REQ-009 SHALL have port in_ready, output, CH bits: per-channel accept; transfer occurs when in_valid[i] & in_ready[i].
REQ-010 SHALL have port v_exch, input, 1 bit: scheduler exchange writeback valid.
REQ-011 SHALL have port task_exch, input, W-1 bits: exchanged task.
REQ-012 SHALL have ports ctrl_rp, ctrl_subtract and ctrl_mq_active, input, 1 bit each: control-unit signals.
REQ-013 SHALL have ports mq_empty and mq_fail, input, 1 bit each: main-queue status.
REQ-014 SHALL have port mq_wr, output, 1 bit: main-queue write strobe.
REQ-015 SHALL have port mq_data, output, W-1 bits: main-queue write data.
REQ-016 SHALL have port mq_rd, output, 1 bit: main-queue read strobe, which is also the scheduler write strobe.
REQ-017 SHALL have ports cnt_accepted, cnt_exch, cnt_invalid, cnt_dropped and cnt_iter, output, CNT_W bits each: statistics.

Function
REQ-018 SHALL drive mq_wr, mq_data, mq_rd and in_ready combinationally from the inputs and registered state, with zero latency.
REQ-019 SHALL give v_exch absolute write priority: mq_wr=1, mq_data=task_exch, all in_ready=0.
REQ-020 SHALL, when v_exch=0 and ctrl_rp=0, grant exactly one requesting channel: the first requester at or after rr_ptr (ARB_MODE 0), or the lowest index (ARB_MODE 1).
REQ-021 SHALL, for a granted channel whose task VALID bit is 1, assert mq_wr with mq_data set to the task's bits [W-2:0].
REQ-022 SHALL, for a granted channel whose task VALID bit is 0, consume the task without mq_wr and increment cnt_invalid.
REQ-023 SHALL hold all in_ready at 0 while ctrl_rp=1; v_exch writes are still accepted during ctrl_rp.
REQ-024 SHALL, in ARB_MODE 0, load rr_ptr with (granted index + 1) mod CH on each grant, wrapping CH-1 to 0; rr_ptr is unchanged when there is no grant.
REQ-025 SHALL compute mq_rd = ~(mq_wr | v_exch | ctrl_rp | ctrl_subtract | mq_empty) & ctrl_mq_active & ~rd_last, where rd_last is mq_rd registered.
REQ-026 SHALL never assert mq_rd and mq_wr in the same cycle, and never assert mq_rd in two consecutive cycles.
REQ-027 SHALL increment cnt_accepted on each valid-task channel write and cnt_exch on each v_exch write.
REQ-028 SHALL increment cnt_dropped on each cycle in which mq_fail=1.
REQ-029 SHALL increment cnt_iter on each falling edge of ctrl_rp, detected against a registered copy of ctrl_rp.
REQ-030 SHALL saturate all counters at all-ones; a saturated counter does not wrap.

Reset
REQ-031 SHALL, while rst=1, clear all counters, rr_ptr, and the registered copy of ctrl_rp.
REQ-032 SHALL set rd_last=1 on reset, so that mq_rd=0 in the first cycle after reset.
REQ-033 SHALL force in_ready=0, mq_wr=0 and mq_rd=0 while rst=1; a reset mid-transfer loses no accepted data, because transfers complete in the same cycle.

Structure
REQ-034 SHALL take the task field positions (VALID, Type, ID, deadline, execution) and the ARB_MODE encodings from the shared scheduler package.
REQ-035 SHALL isolate the grant logic in one sub-module, rr_arbiter (CH requests, rr_ptr, mode input, one-hot grant output).

Verification
REQ-036 SHALL verify: CH=4, ARB_MODE=0, all channels valid with VALID=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; cnt_accepted=8.
REQ-037 SHALL verify: v_exch=1 while channel 2 is valid -> mq_data=task_exch, in_ready=0000, cnt_exch=1, and channel 2 is granted in the next cycle.
REQ-038 SHALL verify: mq_empty=0, ctrl_mq_active=1, no writes for 6 cycles -> mq_rd pattern 0,1,0,1,0,1 after reset deassertion.
REQ-039 SHALL verify: ctrl_rp high for 3 cycles, then low -> in_ready=0 throughout, mq_rd=0, and cnt_iter increments by 1 one cycle after the fall.
REQ-040 SHALL verify: channel 1 offering a task with VALID=0 -> consumed, mq_wr=0, cnt_invalid=1.
REQ-041 SHALL verify: CNT_W=4 and 20 accepted tasks -> cnt_accepted holds at 15.

Source files
------------

// File: rtl/task_ingress_arbiter_pkg.sv
// Shared scheduler definitions: task field layout, arbitration mode encodings
// and a pointer-width helper.
package task_ingress_arbiter_pkg;

  localparam int TASK_W    = 42;
  localparam int VALID_BIT = 41;
  localparam int TYPE_MSB  = 40;
  localparam int TYPE_LSB  = 39;
  localparam int ID_MSB    = 38;
  localparam int ID_LSB    = 32;
  localparam int DL_MSB    = 31;
  localparam int DL_LSB    = 16;
  localparam int EXEC_MSB  = 15;
  localparam int EXEC_LSB  = 0;

  typedef struct packed {
    logic        valid;
    logic [1:0]  kind;
    logic [6:0]  id;
    logic [15:0] deadline;
    logic [15:0] exec;
  } task_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/task_ingress_arbiter_rr.sv
// One-hot grant among CH requests: rotating start at ptr, or lowest index in fixed mode.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter
  import task_ingress_arbiter_pkg::*;
#(
  parameter int CH = 4,
  parameter int PW = 2
) (
  input  logic [CH-1:0] req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [CH-1:0] grant
);

  int  idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < CH; k++) begin
      idx = (mode == ARB_FIXED) ? k : ((int'(ptr) + k) % CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_ingress_arbiter.sv
// Merges CH task sources and the scheduler exchange path into main-queue writes, issues
// main-queue reads, keeps saturating stats. Zero latency; exchange and ctrl_rp stall all sources.
module task_ingress_arbiter
  import task_ingress_arbiter_pkg::*;
#(
  parameter int W        = TASK_W,
  parameter int CH       = 4,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*W-1:0]   in_task,
  output logic [CH-1:0]     in_ready,
  input  logic              v_exch,
  input  logic [W-2:0]      task_exch,
  input  logic              ctrl_rp,
  input  logic              ctrl_subtract,
  input  logic              ctrl_mq_active,
  input  logic              mq_empty,
  input  logic              mq_fail,
  output logic              mq_wr,
  output logic [W-2:0]      mq_data,
  output logic              mq_rd,
  output logic [CNT_W-1:0]  cnt_accepted,
  output logic [CNT_W-1:0]  cnt_exch,
  output logic [CNT_W-1:0]  cnt_invalid,
  output logic [CNT_W-1:0]  cnt_dropped,
  output logic [CNT_W-1:0]  cnt_iter
);

  localparam int PW = idx_w(CH);

  logic [PW-1:0] rr_ptr;
  logic [CH-1:0] req;
  logic [CH-1:0] grant;
  logic [W-1:0]  gtask;
  logic [PW-1:0] gidx;
  logic          any_grant;
  logic          rd_last;
  logic          rp_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sources only compete when neither reset, exchange writeback nor ctrl_rp owns the queue.
  assign req = in_valid & {CH{~rst & ~v_exch & ~ctrl_rp}};

  rr_arbiter #(.CH(CH), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .mode  (ARB_MODE == int'(ARB_FIXED)),
    .grant (grant)
  );

  always_comb begin
    gtask = '0;
    gidx  = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        gtask = in_task[i*W +: W];
        gidx  = PW'(i);
      end
    end
  end

  assign any_grant = |grant;
  assign in_ready  = grant;
  assign mq_wr     = ~rst & (v_exch | (any_grant & gtask[W-1]));
  assign mq_data   = v_exch ? task_exch : gtask[W-2:0];
  assign mq_rd     = ~rst & ~(mq_wr | v_exch | ctrl_rp | ctrl_subtract | mq_empty)
                     & ctrl_mq_active & ~rd_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      rd_last      <= 1'b1;
      rp_q         <= 1'b0;
      cnt_accepted <= '0;
      cnt_exch     <= '0;
      cnt_invalid  <= '0;
      cnt_dropped  <= '0;
      cnt_iter     <= '0;
    end else begin
      rd_last <= mq_rd;
      rp_q    <= ctrl_rp;
      if (ARB_MODE == int'(ARB_RR) && any_grant)
        rr_ptr <= (gidx == PW'(CH - 1)) ? '0 : gidx + PW'(1);
      if (any_grant && gtask[W-1])  cnt_accepted <= sat_inc(cnt_accepted);
      if (any_grant && !gtask[W-1]) cnt_invalid  <= sat_inc(cnt_invalid);
      if (v_exch)                   cnt_exch     <= sat_inc(cnt_exch);
      if (mq_fail)                  cnt_dropped  <= sat_inc(cnt_dropped);
      if (rp_q && !ctrl_rp)         cnt_iter     <= sat_inc(cnt_iter);
    end
  end

endmodule

// File: tb/tb_task_ingress_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share one stimulus set.
module tb_task_ingress_arbiter;
  localparam int W     = 42;
  localparam int CH    = 4;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     in_valid;
  logic [CH*W-1:0]   in_task;
  logic              v_exch;
  logic [W-2:0]      task_exch;
  logic              ctrl_rp, ctrl_subtract, ctrl_mq_active, mq_empty, mq_fail;

  logic [CH-1:0]     in_ready, f_in_ready;
  logic              mq_wr, mq_rd, f_mq_wr, f_mq_rd;
  logic [W-2:0]      mq_data, f_mq_data;
  logic [CNT_W-1:0]  cnt_accepted, cnt_exch, cnt_invalid, cnt_dropped, cnt_iter;
  logic [CNT_W-1:0]  f_acc, f_exch, f_inv, f_drop, f_iter;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] tsk [CH];

  always #5 clk = ~clk;

  task_ingress_arbiter #(.W(W), .CH(CH), .ARB_MODE(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_task(in_task), .in_ready(in_ready),
    .v_exch(v_exch), .task_exch(task_exch), .ctrl_rp(ctrl_rp), .ctrl_subtract(ctrl_subtract),
    .ctrl_mq_active(ctrl_mq_active), .mq_empty(mq_empty), .mq_fail(mq_fail),
    .mq_wr(mq_wr), .mq_data(mq_data), .mq_rd(mq_rd),
    .cnt_accepted(cnt_accepted), .cnt_exch(cnt_exch), .cnt_invalid(cnt_invalid),
    .cnt_dropped(cnt_dropped), .cnt_iter(cnt_iter)
  );

  task_ingress_arbiter #(.W(W), .CH(CH), .ARB_MODE(1), .CNT_W(CNT_W)) dut_fix (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_task(in_task), .in_ready(f_in_ready),
    .v_exch(v_exch), .task_exch(task_exch), .ctrl_rp(ctrl_rp), .ctrl_subtract(ctrl_subtract),
    .ctrl_mq_active(ctrl_mq_active), .mq_empty(mq_empty), .mq_fail(mq_fail),
    .mq_wr(f_mq_wr), .mq_data(f_mq_data), .mq_rd(f_mq_rd),
    .cnt_accepted(f_acc), .cnt_exch(f_exch), .cnt_invalid(f_inv),
    .cnt_dropped(f_drop), .cnt_iter(f_iter)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tasks();
    for (int i = 0; i < CH; i++) in_task[i*W +: W] = tsk[i];
  endtask

  initial begin
    rst = 1'b1; in_valid = '1; v_exch = 1'b0; task_exch = '0;
    ctrl_rp = 1'b0; ctrl_subtract = 1'b0; ctrl_mq_active = 1'b1; mq_empty = 1'b0; mq_fail = 1'b0;
    for (int i = 0; i < CH; i++) tsk[i] = {1'b1, 41'(i * 16 + 5)};
    load_tasks();
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_mq_wr",    64'(mq_wr),    64'h0);
    check("rst_mq_rd",    64'(mq_rd),    64'h0);
    check("rst_cnt_acc",  64'(cnt_accepted), 64'h0);
    check("rst_cnt_iter", 64'(cnt_iter), 64'h0);

    // Read strobe alternation right after reset release, no writes pending.
    in_valid = '0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("mq_rd_%0d", k), 64'(mq_rd), 64'(k % 2));
      step();
    end
    ctrl_mq_active = 1'b0; mq_empty = 1'b1;

    // All four channels busy: round-robin sweep vs fixed priority.
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
      check($sformatf("rr_data_%0d", k),  64'(mq_data),  64'(41'((k % 4) * 16 + 5)));
      check($sformatf("rr_wr_%0d", k),    64'(mq_wr),    64'h1);
      check($sformatf("fix_grant_%0d", k), 64'(f_in_ready), 64'h1);
      step();
    end
    check("cnt_acc_8", 64'(cnt_accepted), 64'd8);

    // Exchange writeback preempts channel 2, which wins the following cycle.
    in_valid = 4'b0100; v_exch = 1'b1; task_exch = 41'h1_2345_6789;
    #1;
    check("exch_data",  64'(mq_data),  64'h1_2345_6789);
    check("exch_ready", 64'(in_ready), 64'h0);
    check("exch_wr",    64'(mq_wr),    64'h1);
    step();
    v_exch = 1'b0;
    check("cnt_exch_1", 64'(cnt_exch), 64'd1);
    #1;
    check("after_exch_grant", 64'(in_ready), 64'b0100);
    step();
    check("cnt_acc_9", 64'(cnt_accepted), 64'd9);

    // ctrl_rp blocks sources and reads, still admits an exchange write.
    in_valid = '1; mq_empty = 1'b0; ctrl_mq_active = 1'b1; ctrl_rp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v_exch = (k == 1);
      #1;
      check($sformatf("rp_ready_%0d", k), 64'(in_ready), 64'h0);
      check($sformatf("rp_rd_%0d", k),    64'(mq_rd),    64'h0);
      check($sformatf("rp_wr_%0d", k),    64'(mq_wr),    64'(k == 1));
      step();
    end
    v_exch = 1'b0; ctrl_rp = 1'b0; in_valid = '0; mq_empty = 1'b1; ctrl_mq_active = 1'b0;
    check("cnt_iter_pre", 64'(cnt_iter), 64'd0);
    check("cnt_exch_2",   64'(cnt_exch), 64'd2);
    step();
    check("cnt_iter_post", 64'(cnt_iter), 64'd1);

    // Channel 1 offers an invalid task; pointer sits at 3 so 1 is reached after wrap.
    tsk[1] = {1'b0, 41'h7};
    load_tasks();
    in_valid = 4'b0010;
    #1;
    check("inv_ready", 64'(in_ready), 64'b0010);
    check("inv_wr",    64'(mq_wr),    64'h0);
    step();
    in_valid = '0;
    check("cnt_invalid", 64'(cnt_invalid), 64'd1);
    check("cnt_acc_inv", 64'(cnt_accepted), 64'd9);

    mq_fail = 1'b1;
    step(); step();
    mq_fail = 1'b0;
    check("cnt_dropped", 64'(cnt_dropped), 64'd2);

    // Eleven more valid tasks bring the total to 20; the 4-bit counter must hold at 15.
    tsk[1] = {1'b1, 41'h15};
    load_tasks();
    in_valid = '1;
    for (int k = 0; k < 11; k++) step();
    in_valid = '0;
    check("cnt_acc_sat", 64'(cnt_accepted), 64'd15);
    step();
    check("cnt_acc_hold", 64'(cnt_accepted), 64'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
